// File: rtl/vga_framebuffer.sv
// vga_framebuffer: 160x120 12-bit frame scanned out at 4x scale.
// One single-port RAM shared by display reads, host writes and a blanking-time clear.
module vga_framebuffer #(
   parameter int FB_W       = 160,
   parameter int FB_H       = 120,
   parameter int SCALE_LOG2 = 2,
   parameter int ADDR_W     = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              h_valid,
   input  logic              v_valid,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [11:0]       wr_data,
   input  logic              clear_start,
   input  logic [11:0]       clear_color,
   output logic              busy,
   output logic              clear_done,
   output logic              hsync,
   output logic              vsync,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b
);
   localparam int unsigned FB_N = FB_W * FB_H;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_N - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [11:0]       r_mem [FB_N];
   logic [11:0]       r_rdata;
   logic [11:0]       r_rgb;
   logic [11:0]       r_color;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_done;
   logic              r_hs1, r_hs2;
   logic              r_vs1, r_vs2;
   logic              r_act1;

   logic              w_active;
   logic              w_ext_we;
   logic              w_clr_we;
   logic              w_last;
   logic [ADDR_W-1:0] w_fb_x;
   logic [ADDR_W-1:0] w_fb_y;
   logic [ADDR_W-1:0] w_rd_addr;

   assign w_active  = h_valid && v_valid;
   assign w_fb_x    = ADDR_W'(x >> SCALE_LOG2);
   assign w_fb_y    = ADDR_W'(y >> SCALE_LOG2);
   assign w_rd_addr = w_fb_y * ADDR_W'(FB_W) + w_fb_x;

   assign wr_ready = (r_state == IDLE) && !clear_start && !w_active;
   assign w_ext_we = wr_valid && wr_ready && !rst
                     && (32'(wr_addr) < FB_N);
   assign w_clr_we = (r_state == CLEAR) && !w_active && !rst;
   assign w_last   = (r_ptr == LAST);

   // Active cycles own the RAM; blanking cycles carry black instead.
   always_ff @(posedge clk) begin
      if (w_active) begin
         r_rdata <= r_mem[w_rd_addr];
      end else begin
         r_rdata <= '0;
         if (w_ext_we)
            r_mem[wr_addr] <= wr_data;
         else if (w_clr_we)
            r_mem[r_ptr] <= r_color;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  if (clear_start) w_next = CLEAR;
         CLEAR: if (!w_active && w_last) w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == CLEAR) && (w_next == IDLE);
         if (r_state == IDLE && clear_start) begin
            r_color <= clear_color;
            r_ptr   <= '0;
         end else if (r_state == CLEAR && !w_active) begin
            r_ptr <= r_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs1  <= 1'b1;
         r_hs2  <= 1'b1;
         r_vs1  <= 1'b1;
         r_vs2  <= 1'b1;
         r_act1 <= 1'b0;
         r_rgb  <= '0;
      end else begin
         r_hs1  <= hsync_in;
         r_hs2  <= r_hs1;
         r_vs1  <= vsync_in;
         r_vs2  <= r_vs1;
         r_act1 <= w_active;
         r_rgb  <= r_act1 ? r_rdata : 12'h000;
      end
   end

   assign busy       = (r_state == CLEAR);
   assign clear_done = r_done;
   assign hsync      = r_hs2;
   assign vsync      = r_vs2;
   assign {vga_r, vga_g, vga_b} = r_rgb;

endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Scaled framebuffer pixel source between `vga_sync` and the VGA pins. Holds a 160×120 frame of 12-bit RGB in a single-port RAM and reads it at 4× scale using the `x`, `y`, `h_valid` and `v_valid` values from `vga_sync`. Outputs `hsync`, `vsync` and colour, delayed so all three stay aligned. A write port and a hardware clear engine load the RAM, but only during blanking, so display reads never collide with writes.

## Interface
- `FB_W`, default 160: framebuffer width in pixels.
- `FB_H`, default 120: framebuffer height in pixels.
- `SCALE_LOG2`, default 2: display-to-framebuffer shift (4× scale).
- `ADDR_W`, default 15: RAM address width, at least ceil(log2(FB_W*FB_H)).

Ports:
- `clk`, input, 1: pixel clock (25 MHz); one clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `hsync_in`, `vsync_in`, input, 1 each: syncs from `vga_sync`.
- `h_valid`, `v_valid`, input, 1 each: active-region flags from `vga_sync`.
- `x`, `y`, input, 10 each: display coordinates from `vga_sync`.
- `wr_valid`, input, 1: write request.
- `wr_ready`, output, 1: write accepted this cycle when high together with `wr_valid`.
- `wr_addr`, input, ADDR_W: linear address, y*FB_W + x.
- `wr_data`, input, 12: {r,g,b}.
- `clear_start`, input, 1: single-cycle pulse that starts a full-frame clear.
- `clear_color`, input, 12: fill value, sampled on the cycle `clear_start` is accepted.
- `busy`, output, 1: clear in progress.
- `clear_done`, output, 1: single-cycle pulse when a clear completes.
- `hsync`, `vsync`, output, 1 each: delayed syncs.
- `vga_r`, `vga_g`, `vga_b`, output, 4 each: pixel colour.

## Operation
- `active = h_valid && v_valid`. The RAM has one port; in any cycle it does exactly one of: display read, external write, clear write.
- **Display read.** When `active`, address = (y>>SCALE_LOG2)*FB_W + (x>>SCALE_LOG2). The multiply may be shift-add (160 = 128+32).
  - When not `active`, no read is issued and the colour pipeline carries black (12'h000).
- **Write port.**
  - `wr_ready = (state==IDLE) && !clear_start && !active`; combinational.
  - A transfer happens when `wr_valid && wr_ready`.
  - If `wr_addr >= FB_W*FB_H`, the transfer is accepted (handshake completes) and the data is dropped.
- **Clear engine.** FSM states: IDLE and CLEAR.
  - IDLE → CLEAR on `clear_start`. Latch `clear_color` and set the clear pointer to 0.
  - In CLEAR, on each non-`active` cycle: write `clear_color` to the pointer address, then increment the pointer. On `active` cycles the clear pauses and the pointer holds.
  - After writing address FB_W*FB_H-1: return to IDLE and pulse `clear_done` for one cycle (the cycle after that last write).
  - `clear_start` is ignored while in CLEAR.
  - `busy = (state==CLEAR)`.
- **Simultaneous events.**
  - `clear_start` together with `wr_valid` in IDLE: the clear wins and `wr_ready` is 0 that cycle.
  - A write followed by a display read of the same address: the write is visible to any read issued on a later cycle.
- **Reset.**
  - `hsync` = 1, `vsync` = 1, RGB = 0, `busy` = 0, `clear_done` = 0, state = IDLE, pipeline valid bits cleared.
  - Reset during CLEAR aborts the clear. RAM contents are not reset; a partially cleared frame stays as it is.

## Timing
- Fixed 2-cycle latency from inputs to outputs.
  - Cycle N: `x`, `y`, `active`, `hsync_in`, `vsync_in` sampled; RAM address registered.
  - Cycle N+1: RAM data registered.
  - Cycle N+2: that value appears on `vga_r`/`vga_g`/`vga_b`.
- `hsync_in`, `vsync_in` and `active` pass through a matching 2-stage delay. RGB is forced to 0 when the delayed `active` is 0.
- Output pixel count per line and per frame is unchanged: 800×525 clocks.
- Clear duration: FB_W*FB_H = 19200 write slots, spread over non-`active` cycles only.
  - A frame has 420000 − 307200 = 112800 blanking cycles, so a clear finishes within one frame when started at the start of vertical blanking.

## Test plan
- **Reset.** Hold `rst` 3 cycles mid-line → `hsync`=1, `vsync`=1, RGB=0, `busy`=0. After release, output syncs equal the input syncs delayed by exactly 2 clocks.
- **Write and readback.** During blanking, write addr 0 = 12'hF00 and addr 161 (x=1, y=1) = 12'h0F0.
  - Display (0..3,0..3) → RGB F,0,0 two cycles after each pixel.
  - Display (4..7,4..7) → 0,F,0.
- **Write blocked during active.** `wr_valid` held high from inside the active region → `wr_ready`=0 until the first blanking cycle, then exactly one transfer. The display is unaffected.
- **Out-of-range write.** `wr_addr`=19200 → handshake completes; a full-frame readback is unchanged.
- **Full clear.** `clear_start` with `clear_color`=12'h0AF.
  - `busy`=1 next cycle; `clear_done` pulses once; every display pixel in the next frame is 0,A,F.
  - A second `clear_start` while busy is ignored.
- **Reset mid-clear.** Assert `rst` about 5000 writes into a clear → `busy`=0, no `clear_done` pulse, write port ready again in blanking.
